inv_zigzag_coeff_buffer: RTL and testbench
==========================================

INV_ZIGZAG_COEFF_BUFFER -- requirements
Module: inv_zigzag_coeff_buffer

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clock `clk`; reset `reset`, synchronous, active-high.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  — system clock.
- reset  in  1  — synchronous active-high reset.
- blk_valid  in  1  — a decoded residual block (the CAVLC end-of-block pulse) is present on coeff_in.
- blk_ready  out  1  — a bank is free to accept a block.
- coeff_in  in  144  — 16 x 9-bit signed levels in scan order; lane k = bits [9k+8:9k].
- maxNumCoeff  in  5  — block type: 16, 15 or 4.
- out_valid  out  1  — out_row, out_coeff and out_last are valid.
- out_ready  in  1  — the consumer (IQIT) accepts the current beat.
- out_coeff  out  36  — 4 x 9-bit signed coefficients of one raster row; lane c = column c.
- out_row  out  2  — raster row index of the current beat.
- out_last  out  1  — final beat of the block.
- out_allzero  out  1  — every coefficient of the current block is zero.

Function
REQ-003 A block SHALL be captured on any clock edge where blk_valid and blk_ready are both high.
- On that edge, coeff_in, maxNumCoeff and an all-zero flag are written into the write bank.
REQ-004 Storage SHALL be two ping-pong banks with a write pointer, a read pointer and an occupancy count in the range 0..2.
- blk_ready = (count < 2).
REQ-005 Mapping for maxNumCoeff=16: scan index s SHALL map to raster position p (row = p/4, column = p%4):
- s = 0..15 → p = 0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15.
REQ-006 Mapping for maxNumCoeff=15: lane k SHALL take scan index k+1 for k = 0..14.
- Raster position 0 outputs 0.
- Lane 15 is ignored.
REQ-007 For maxNumCoeff=4 (chroma DC 2x2), the block SHALL produce one beat: out_row=0, lanes 0..3 = coeff_in lanes 0..3, out_last=1.
REQ-008 For maxNumCoeff of 16 or 15, the block SHALL produce four beats with out_row = 0, 1, 2, 3; out_last = 1 on row 3 only.
REQ-009 The output handshake:
- A beat SHALL advance only on an edge where out_valid and out_ready are both high.
- out_coeff, out_row, out_last and out_allzero SHALL hold stable while out_valid=1 and out_ready=0.
REQ-010 out_valid SHALL be high whenever count > 0; the outputs are driven combinationally from the read bank and the row counter.
REQ-011 Latency: a block captured into an empty buffer at edge N SHALL present row 0 with out_valid=1 in the cycle after edge N.
REQ-012 When the last beat is accepted:
- The read pointer toggles, the row counter clears and count decrements.
- If the other bank is full, its row 0 is presented in the next cycle with no bubble.
REQ-013 If a capture and a last-beat acceptance occur on the same edge, count SHALL remain unchanged and both pointers SHALL toggle.
REQ-014 blk_valid while blk_ready=0 SHALL be ignored: no state change.
- Dropping such a block is an upstream protocol violation, not recovered here.
REQ-015 An unsupported maxNumCoeff value SHALL be treated as 16.
REQ-016 Coefficient values SHALL pass through unmodified at 9 bits: no sign extension, saturation or arithmetic.

Reset
REQ-017 When reset=1 at an edge, the block SHALL set count=0, both pointers=0 and the row counter=0.
- Consequently blk_ready=1, out_valid=0, out_row=0, out_last=0, out_allzero=0 and out_coeff=0 in the following cycle.
REQ-018 Reset SHALL override a simultaneous capture or beat acceptance.
- Any block in progress is discarded.
- Bank contents need not be cleared.

Structure
REQ-019 The following SHALL be shared constants in nova_defines.v:
- Coefficient width 9.
- Block-type codes 16/15/4.
- The 16-entry zigzag table.
REQ-020 The scan→raster lookup SHALL be a combinational sub-module, inv_zigzag_map: inputs maxNumCoeff and a 144-bit scan vector; output a 144-bit raster vector.
- It SHALL be instantiated once, on the capture path, so that banks store data in raster order.
REQ-021 The top level SHALL contain only the banks, pointers, count and row counter, plus the output multiplexing; the target size is 120–400 RTL lines.

Verification
REQ-022 4x4 mapping: coeff_in lane s = s+1 (values 1..16), maxNumCoeff=16, out_ready=1 → rows SHALL be {1,2,6,7}, {3,5,8,13}, {4,9,12,14}, {10,11,15,16}; out_last only on row 3; out_allzero=0.
REQ-023 AC block: same stimulus with maxNumCoeff=15 → row 0 SHALL be {0,1,5,6}; row 3 SHALL be {9,10,14,15}.
REQ-024 Chroma DC: lanes {-3,2,0,7}, maxNumCoeff=4 → exactly one beat {-3,2,0,7}, out_row=0, out_last=1, asserted the cycle after capture.
REQ-025 Back-pressure: three consecutive blk_valid pulses with out_ready=0:
- Blocks 1 and 2 SHALL be captured and blk_ready SHALL fall.
- Outputs SHALL hold.
- Releasing out_ready SHALL drain 8 beats with no bubble between blocks.
REQ-026 Simultaneous events and reset:
- Capture on the same edge as a last-beat acceptance → count SHALL stay at 1.
- reset asserted mid-drain at row 2 → out_valid=0 and blk_ready=1 in the next cycle; the following block SHALL start at row 0.
- An all-zero block SHALL give out_allzero=1 on all four beats.

Source files
------------

// File: rtl/inv_zigzag_coeff_buffer_pkg.sv
// Shared constants for the inverse-zigzag coefficient buffer: widths, block-type
// codes and the 4x4 zigzag scan table.
package inv_zigzag_coeff_buffer_pkg;

  localparam int COEFF_W   = 9;
  localparam int NUM_LANES = 16;
  localparam int ROW_LANES = 4;
  localparam int BLK_W     = NUM_LANES * COEFF_W;
  localparam int ROW_W     = ROW_LANES * COEFF_W;

  localparam logic [4:0] MNC_4X4 = 5'd16;
  localparam logic [4:0] MNC_AC  = 5'd15;
  localparam logic [4:0] MNC_DC  = 5'd4;

  // ZIGZAG[s] = raster position of scan index s
  localparam logic [NUM_LANES-1:0][3:0] ZIGZAG = {
    4'd15, 4'd14, 4'd11, 4'd7, 4'd10, 4'd13, 4'd12, 4'd9,
    4'd6,  4'd3,  4'd2,  4'd5, 4'd8,  4'd4,  4'd1,  4'd0
  };

  typedef enum logic [1:0] {KIND_4X4, KIND_AC, KIND_DC} blk_kind_e;

  // Unknown codes fall back to a full 4x4 block
  function automatic blk_kind_e decode_kind(input logic [4:0] mnc);
    blk_kind_e k;
    case (mnc)
      MNC_AC:  k = KIND_AC;
      MNC_DC:  k = KIND_DC;
      default: k = KIND_4X4;
    endcase
    return k;
  endfunction

  function automatic int raster_to_scan(input int p);
    int s_found;
    s_found = 0;
    for (int s = 0; s < NUM_LANES; s++)
      if (int'(ZIGZAG[s]) == p) s_found = s;
    return s_found;
  endfunction

endpackage

// File: rtl/inv_zigzag_coeff_buffer_map.sv
// Combinational scan-to-raster reorder for 4x4, AC (15) and chroma DC (4) blocks.
module inv_zigzag_map
  import inv_zigzag_coeff_buffer_pkg::*;
(
  input  logic [4:0]                              maxNumCoeff,
  input  logic [NUM_LANES-1:0][COEFF_W-1:0]       i_scan,
  output logic [NUM_LANES-1:0][COEFF_W-1:0]       o_raster
);

  blk_kind_e w_kind;
  assign w_kind = decode_kind(maxNumCoeff);

  for (genvar p = 0; p < NUM_LANES; p++) begin : g_lane
    localparam int S   = raster_to_scan(p);
    // AC blocks arrive shifted down one lane; scan index 0 (DC) is absent
    localparam int SM1 = (S == 0) ? 0 : S - 1;
    logic [COEFF_W-1:0] w_lane;

    always_comb begin
      w_lane = '0;
      case (w_kind)
        KIND_DC:  w_lane = (p < ROW_LANES) ? i_scan[p] : '0;
        KIND_AC:  w_lane = (S == 0) ? '0 : i_scan[SM1];
        default:  w_lane = i_scan[S];
      endcase
    end

    assign o_raster[p] = w_lane;
  end

endmodule

// File: rtl/inv_zigzag_coeff_buffer.sv
// Two-bank ping-pong buffer: captures a scan-order block in raster order and
// streams it out one 4-coefficient row per beat.
module inv_zigzag_coeff_buffer
  import inv_zigzag_coeff_buffer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [BLK_W-1:0]   coeff_in,
  input  logic [4:0]         maxNumCoeff,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ROW_W-1:0]   out_coeff,
  output logic [1:0]         out_row,
  output logic               out_last,
  output logic               out_allzero
);

  logic [1:0][BLK_W-1:0] r_bank;
  logic [1:0]            r_dc;
  logic [1:0]            r_zero;
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_cnt;
  logic [1:0]            r_row;

  logic [BLK_W-1:0]      w_raster;
  logic                  w_cap;
  logic                  w_beat;
  logic                  w_done;

  inv_zigzag_map u_map (
    .maxNumCoeff (maxNumCoeff),
    .i_scan      (coeff_in),
    .o_raster    (w_raster)
  );

  assign blk_ready   = (r_cnt < 2'd2);
  assign out_valid   = (r_cnt != 2'd0);
  assign w_cap       = blk_valid & blk_ready;
  assign w_beat      = out_valid & out_ready;
  assign w_done      = w_beat & out_last;

  // Chroma DC is a single-beat block; everything else ends on row 3
  assign out_last    = out_valid & (r_dc[r_rptr] | (r_row == 2'd3));
  assign out_row     = r_row;
  assign out_allzero = out_valid & r_zero[r_rptr];
  assign out_coeff   = out_valid ? r_bank[r_rptr][r_row*ROW_W +: ROW_W] : '0;

  always_ff @(posedge clk) begin
    if (w_cap && !reset) begin
      r_bank[r_wptr] <= w_raster;
      r_dc[r_wptr]   <= (decode_kind(maxNumCoeff) == KIND_DC);
      r_zero[r_wptr] <= (w_raster == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= 2'd0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_row  <= 2'd0;
    end else begin
      if (w_cap) r_wptr <= ~r_wptr;
      if (w_done) begin
        r_rptr <= ~r_rptr;
        r_row  <= 2'd0;
      end else if (w_beat) begin
        r_row  <= r_row + 2'd1;
      end
      case ({w_cap, w_done})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_zigzag_coeff_buffer.sv
// Randomized + directed bench for inv_zigzag_coeff_buffer against a queue-of-blocks model.
module tb_inv_zigzag_coeff_buffer;

  logic         clk = 1'b0;
  logic         reset, blk_valid, out_ready;
  logic [143:0] coeff_in;
  logic [4:0]   maxNumCoeff;
  logic         blk_ready, out_valid, out_last, out_allzero;
  logic [35:0]  out_coeff;
  logic [1:0]   out_row;

  inv_zigzag_coeff_buffer dut (
    .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .coeff_in(coeff_in), .maxNumCoeff(maxNumCoeff), .out_valid(out_valid),
    .out_ready(out_ready), .out_coeff(out_coeff), .out_row(out_row),
    .out_last(out_last), .out_allzero(out_allzero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0][8:0] r;
    logic             dc;
    logic             zero;
  } blk_t;

  typedef struct {
    logic [35:0] c;
    logic [1:0]  row;
    logic        last;
    logic        zero;
    int          cyc;
  } beat_t;

  blk_t  mq[$];
  beat_t log_q[$];
  int    mrow = 0;
  int    cyc = 0;
  int    cap_cyc = 0;
  bit    post_rst = 0;
  int    zz[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic blk_t model_block(input logic [143:0] lanes, input logic [4:0] mnc);
    blk_t b;
    logic [15:0][8:0] l;
    l = lanes;
    b.r = '0;
    b.dc = 1'b0;
    if (mnc == 5'd4) begin
      b.dc = 1'b1;
      for (int i = 0; i < 4; i++) b.r[i] = l[i];
    end else if (mnc == 5'd15) begin
      for (int k = 0; k < 15; k++) b.r[zz[k+1]] = l[k];
    end else begin
      for (int s = 0; s < 16; s++) b.r[zz[s]] = l[s];
    end
    b.zero = (b.r == '0);
    return b;
  endfunction

  function automatic logic [35:0] pack4(input int a, input int b, input int c, input int d);
    return {9'(d), 9'(c), 9'(b), 9'(a)};
  endfunction

  function automatic logic [143:0] seq(input int base);
    logic [143:0] v;
    for (int s = 0; s < 16; s++) v[s*9 +: 9] = 9'(base + s);
    return v;
  endfunction

  // Compare against the model, then advance the model to the state after the next edge
  always @(negedge clk) begin
    bit cap_ok;
    cyc++;
    cap_ok = (mq.size() < 2);
    if (post_rst) begin
      chk("rst_coeff", out_coeff, 0);
      chk("rst_row", out_row, 0);
      chk("rst_last", out_last, 0);
      chk("rst_allzero", out_allzero, 0);
    end
    chk("blk_ready", blk_ready, cap_ok);
    chk("out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      logic [35:0] erow;
      logic        elast;
      erow  = mq[0].r[mrow*4 +: 4];
      elast = mq[0].dc || (mrow == 3);
      chk("out_coeff", out_coeff, erow);
      chk("out_row", out_row, mrow);
      chk("out_last", out_last, elast);
      chk("out_allzero", out_allzero, mq[0].zero);
      if (out_ready && !reset) begin
        log_q.push_back('{c: out_coeff, row: out_row, last: out_last, zero: out_allzero, cyc: cyc});
        if (elast) begin
          void'(mq.pop_front());
          mrow = 0;
        end else begin
          mrow++;
        end
      end
    end
    post_rst = reset;
    if (reset) begin
      mq.delete();
      mrow = 0;
    end else if (blk_valid && cap_ok) begin
      mq.push_back(model_block(coeff_in, maxNumCoeff));
      cap_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [143:0] v, input logic [4:0] mnc);
    coeff_in = v;
    maxNumCoeff = mnc;
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (mq.size() > 0 && n < 60) begin
      tick();
      n++;
    end
    chk("drain_bound", n < 60, 1);
  endtask

  task automatic wait_row(input int r);
    int n = 0;
    while (!(mq.size() > 0 && mrow == r) && n < 40) begin
      tick();
      n++;
    end
    chk("wait_row_bound", n < 40, 1);
  endtask

  task automatic chk_consecutive(input string name);
    for (int i = 1; i < log_q.size(); i++)
      chk(name, log_q[i].cyc - log_q[i-1].cyc, 1);
  endtask

  initial begin
    reset = 1'b1; blk_valid = 1'b0; out_ready = 1'b0;
    coeff_in = '0; maxNumCoeff = 5'd16;
    tick(); tick();
    reset = 1'b0;
    tick();

    // 4x4 mapping with values 1..16
    log_q.delete();
    out_ready = 1'b1;
    send(seq(1), 5'd16);
    drain();
    chk("m16_beats", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("m16_row0", log_q[0].c, pack4(1, 2, 6, 7));
      chk("m16_row1", log_q[1].c, pack4(3, 5, 8, 13));
      chk("m16_row2", log_q[2].c, pack4(4, 9, 12, 14));
      chk("m16_row3", log_q[3].c, pack4(10, 11, 15, 16));
      chk("m16_last", {log_q[0].last, log_q[1].last, log_q[2].last, log_q[3].last}, 4'b0001);
      chk("m16_zero", log_q[0].zero, 0);
      chk("m16_latency", log_q[0].cyc, cap_cyc + 1);
    end

    // AC block: DC position zero, lane 15 dropped
    log_q.delete();
    send(seq(1), 5'd15);
    drain();
    chk("m15_beats", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("m15_row0", log_q[0].c, pack4(0, 1, 5, 6));
      chk("m15_row3", log_q[3].c, pack4(9, 10, 14, 15));
    end

    // Chroma DC 2x2
    log_q.delete();
    begin
      logic [143:0] v;
      v = '0;
      v[35:0] = pack4(-3, 2, 0, 7);
      v[143:36] = {12{9'h55}};
      send(v, 5'd4);
    end
    drain();
    chk("dc_beats", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("dc_coeff", log_q[0].c, pack4(-3, 2, 0, 7));
      chk("dc_row", log_q[0].row, 0);
      chk("dc_last", log_q[0].last, 1);
      chk("dc_latency", log_q[0].cyc, cap_cyc + 1);
    end

    // Unsupported block type behaves as 16
    log_q.delete();
    send(seq(1), 5'd7);
    drain();
    chk("mbad_beats", log_q.size(), 4);
    if (log_q.size() == 4) chk("mbad_row1", log_q[1].c, pack4(3, 5, 8, 13));

    // Back-pressure: third block rejected, outputs hold, drain without bubbles
    log_q.delete();
    out_ready = 1'b0;
    maxNumCoeff = 5'd16;
    blk_valid = 1'b1;
    coeff_in = seq(1);  tick();
    coeff_in = seq(17); tick();
    coeff_in = seq(33); tick();
    blk_valid = 1'b0;
    chk("bp_ready", blk_ready, 0);
    chk("bp_hold0", out_coeff, pack4(1, 2, 6, 7));
    tick(); tick();
    chk("bp_hold1", out_coeff, pack4(1, 2, 6, 7));
    chk("bp_hold_row", out_row, 0);
    drain();
    chk("bp_beats", log_q.size(), 8);
    if (log_q.size() == 8) begin
      chk("bp_blk2_row0", log_q[4].c, pack4(17, 18, 22, 23));
      chk("bp_last", log_q[7].last, 1);
      chk_consecutive("bp_no_bubble");
    end

    // Capture on the same edge as last-beat acceptance
    log_q.delete();
    send(seq(1), 5'd16);
    wait_row(3);
    send(seq(40), 5'd16);
    chk("sim_valid", out_valid, 1);
    chk("sim_ready", blk_ready, 1);
    chk("sim_row", out_row, 0);
    chk("sim_coeff", out_coeff, pack4(40, 41, 45, 46));
    drain();
    chk("sim_beats", log_q.size(), 8);
    chk_consecutive("sim_no_bubble");

    // Reset mid-drain at row 2
    send(seq(1), 5'd16);
    wait_row(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", blk_ready, 1);
    log_q.delete();
    send(seq(60), 5'd16);
    drain();
    chk("post_rst_beats", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("post_rst_row0", log_q[0].row, 0);
      chk("post_rst_coeff0", log_q[0].c, pack4(60, 61, 65, 66));
    end

    // All-zero block
    log_q.delete();
    send('0, 5'd16);
    drain();
    chk("zero_beats", log_q.size(), 4);
    for (int i = 0; i < log_q.size(); i++) begin
      chk("zero_flag", log_q[i].zero, 1);
      chk("zero_coeff", log_q[i].c, 0);
    end

    // Randomized traffic; the negedge monitor checks every cycle
    for (int n = 0; n < 1500; n++) begin
      int r;
      blk_valid = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) == 0);
      r = $urandom_range(0, 7);
      if (r < 3)      maxNumCoeff = 5'd16;
      else if (r < 5) maxNumCoeff = 5'd15;
      else if (r < 7) maxNumCoeff = 5'd4;
      else            maxNumCoeff = 5'($urandom);
      for (int s = 0; s < 16; s++)
        coeff_in[s*9 +: 9] = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom);
      if ($urandom_range(0, 7) == 0) coeff_in = '0;
      tick();
    end
    blk_valid = 1'b0;
    reset = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
